// File: rtl/tx_pkg.sv
// Shared constants for the TX recirculation / return routing blocks.
package tx_pkg;
    localparam int   DATA_W_DEF  = 32;
    localparam logic MODE_RETURN = 1'b0;
    localparam logic MODE_RECIR  = 1'b1;
endpackage

// File: rtl/recirc_ret_fifo.sv
// Single-lane show-ahead return FIFO; a push while full is accepted only when a pop frees a slot.
module recirc_ret_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full,
    output logic              ovf
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              pop_ok, push_ok;

    assign valid   = (count != '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign head    = valid ? mem[rd_ptr] : '0;
    // an empty FIFO ignores the pop, so push+pop on empty just stores the word
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);
    assign ovf     = push && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/recirc_router_fifo.sv
// Steers lanes to registered recirculation outputs or per-lane return FIFOs;
// the mode only changes on all-idle cycles so a burst never splits.
module recirc_router_fifo
    import tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    active,
    input  logic [LANES-1:0]        valid_in,
    input  logic [LANES*DATA_W-1:0] data_in,
    output logic                    mode_q,
    output logic [LANES-1:0]        valid_out_recir,
    output logic [LANES*DATA_W-1:0] data_out_recir,
    input  logic [LANES-1:0]        ret_pop,
    output logic [LANES-1:0]        ret_valid,
    output logic [LANES*DATA_W-1:0] data_out_ret,
    output logic [LANES-1:0]        ret_full,
    output logic [LANES-1:0]        overflow
);
    logic [LANES-1:0][DATA_W-1:0] din_l, recir_q, head_l;
    logic [LANES-1:0]             push, ovf;

    assign din_l          = data_in;
    assign data_out_recir = recir_q;
    assign data_out_ret   = head_l;
    assign push           = (mode_q == MODE_RETURN) ? valid_in : '0;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mode_q          <= MODE_RETURN;
            valid_out_recir <= '0;
            recir_q         <= '0;
            overflow        <= '0;
        end else begin
            if (valid_in == '0) mode_q <= active;
            // steering uses the pre-edge mode; idle lanes drive zero data
            for (int i = 0; i < LANES; i++) begin
                valid_out_recir[i] <= (mode_q == MODE_RECIR) && valid_in[i];
                recir_q[i]         <= ((mode_q == MODE_RECIR) && valid_in[i]) ? din_l[i] : '0;
            end
            overflow <= overflow | ovf;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        recirc_ret_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .PTR_W  (PTR_W)
        ) u_fifo (
            .clk     (clk),
            .reset_L (reset_L),
            .push    (push[g]),
            .pop     (ret_pop[g]),
            .din     (din_l[g]),
            .head    (head_l[g]),
            .valid   (ret_valid[g]),
            .full    (ret_full[g]),
            .ovf     (ovf[g])
        );
    end
endmodule

// File: tb/tb_recirc_router_fifo.sv
// Scoreboard bench for recirc_router_fifo: stimulus queues expectations, a negedge monitor checks outputs.
module tb_recirc_router_fifo;
    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int DEPTH  = 4;
    localparam int BW     = LANES*DATA_W;

    logic              clk, reset_L, active, mode_q;
    logic [LANES-1:0]  valid_in, valid_out_recir, ret_pop, ret_valid, ret_full, overflow;
    logic [BW-1:0]     data_in, data_out_recir, data_out_ret;

    typedef struct {
        logic [LANES-1:0] v;
        logic [BW-1:0]    d;
    } rec_t;

    rec_t              exp_recir[$];
    logic [DATA_W-1:0] exp_ret[LANES][$];
    int                checks = 0;
    int                errors = 0;

    recirc_router_fifo #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .active          (active),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .mode_q          (mode_q),
        .valid_out_recir (valid_out_recir),
        .data_out_recir  (data_out_recir),
        .ret_pop         (ret_pop),
        .ret_valid       (ret_valid),
        .data_out_ret    (data_out_ret),
        .ret_full        (ret_full),
        .overflow        (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: recirculation outputs and popped return heads
    initial begin
        rec_t r;
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset_L) begin
                if (valid_out_recir != '0 || data_out_recir != '0) begin
                    if (exp_recir.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL recir_unexpected: got v=%0h d=%0h expected idle", valid_out_recir, data_out_recir);
                    end else begin
                        r = exp_recir.pop_front();
                        chk("recir_valid", BW'(valid_out_recir), BW'(r.v));
                        chk("recir_data", data_out_recir, r.d);
                    end
                end
                for (int i = 0; i < LANES; i++) begin
                    if (ret_pop[i] && ret_valid[i]) begin
                        if (exp_ret[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL ret_unexpected lane%0d: got %0h expected none", i, data_out_ret[i*DATA_W +: DATA_W]);
                        end else begin
                            e = exp_ret[i].pop_front();
                            chk($sformatf("ret_data_l%0d", i), BW'(data_out_ret[i*DATA_W +: DATA_W]), BW'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rec_t r;
        reset_L  = 1'b0;
        active   = 1'b0;
        valid_in = '0;
        data_in  = '0;
        ret_pop  = '0;
        #13;
        chk("rst_mode", BW'(mode_q), 128'h0);
        chk("rst_recir_v", BW'(valid_out_recir), 128'h0);
        chk("rst_recir_d", data_out_recir, 128'h0);
        chk("rst_ret_valid", BW'(ret_valid), 128'h0);
        chk("rst_ret_data", data_out_ret, 128'h0);
        chk("rst_ret_full", BW'(ret_full), 128'h0);
        chk("rst_overflow", BW'(overflow), 128'h0);
        step();
        reset_L = 1'b1;

        // idle cycle applies active=1
        active = 1'b1;
        step();
        chk("mode_recir", BW'(mode_q), 128'h1);
        valid_in = 4'b1111;
        data_in  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        r.v = 4'b1111; r.d = data_in; exp_recir.push_back(r);
        step();
        chk("recir_no_ret", BW'(ret_valid), 128'h0);

        // burst continues while active drops; mode must hold until idle
        data_in = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        r.v = 4'b1111; r.d = data_in; exp_recir.push_back(r);
        step();
        active   = 1'b0;
        valid_in = 4'b0011;
        data_in  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        r.v = 4'b0011; r.d = {64'h0, 32'hC1, 32'hC0}; exp_recir.push_back(r);
        step();
        chk("mode_hold_burst", BW'(mode_q), 128'h1);
        valid_in = '0;
        step();
        chk("mode_return", BW'(mode_q), 128'h0);

        // fill lane0 past DEPTH
        data_in = '0;
        for (int k = 1; k <= 5; k++) begin
            valid_in = 4'b0001;
            data_in[31:0] = 32'(k);
            if (k <= DEPTH) exp_ret[0].push_back(32'(k));
            step();
            if (k == DEPTH) begin
                chk("full_at_depth", BW'(ret_full), 128'h1);
                chk("no_ovf_at_depth", BW'(overflow), 128'h0);
            end
        end
        chk("ovf_set", BW'(overflow), 128'h1);
        chk("full_after_drop", BW'(ret_full), 128'h1);
        chk("head_after_drop", BW'(data_out_ret[31:0]), 128'h1);

        // full + simultaneous pop and push
        data_in[31:0] = 32'h9;
        ret_pop = 4'b0001;
        exp_ret[0].push_back(32'h9);
        step();
        chk("full_pushpop_full", BW'(ret_full), 128'h1);
        chk("full_pushpop_ovf", BW'(overflow), 128'h1);
        valid_in = '0;
        repeat (4) step();
        ret_pop = '0;
        chk("drained", BW'(ret_valid), 128'h0);

        // pop on empty lane1
        ret_pop = 4'b0010;
        step();
        ret_pop = '0;
        chk("pop_empty_valid", BW'(ret_valid), 128'h0);
        chk("pop_empty_data", data_out_ret, 128'h0);
        chk("pop_empty_ovf", BW'(overflow), 128'h1);

        // push+pop on empty lane2
        valid_in = 4'b0100;
        data_in  = {32'h0, 32'h77, 32'h0, 32'h0};
        ret_pop  = 4'b0100;
        exp_ret[2].push_back(32'h77);
        step();
        valid_in = '0;
        ret_pop  = '0;
        chk("pushpop_empty_valid", BW'(ret_valid), 128'h4);
        chk("pushpop_empty_head", BW'(data_out_ret[64 +: 32]), 128'h77);
        ret_pop = 4'b0100;
        step();
        ret_pop = '0;
        chk("lane2_drained", BW'(ret_valid), 128'h0);

        // partly fill, switch to recirc, then reset asynchronously mid-cycle
        valid_in = 4'b1001;
        data_in  = {32'h31, 32'h0, 32'h0, 32'h11};
        step();
        valid_in = 4'b0001;
        data_in  = {32'h0, 32'h0, 32'h0, 32'h12};
        step();
        chk("prefill_valid", BW'(ret_valid), 128'h9);
        valid_in = '0;
        active   = 1'b1;
        step();
        valid_in = 4'b0010;
        data_in  = {32'h0, 32'h0, 32'hEE, 32'h0};
        step();
        chk("prereset_recir", BW'(valid_out_recir), 128'h2);
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst_mode", BW'(mode_q), 128'h0);
        chk("arst_recir_v", BW'(valid_out_recir), 128'h0);
        chk("arst_recir_d", data_out_recir, 128'h0);
        chk("arst_ret_valid", BW'(ret_valid), 128'h0);
        chk("arst_ret_data", data_out_ret, 128'h0);
        chk("arst_ret_full", BW'(ret_full), 128'h0);
        chk("arst_overflow", BW'(overflow), 128'h0);
        valid_in = '0;
        active   = 1'b0;
        data_in  = '0;
        step();
        reset_L = 1'b1;
        step();
        chk("post_rst_valid", BW'(ret_valid), 128'h0);
        chk("post_rst_mode", BW'(mode_q), 128'h0);

        // stale entries must not reappear after reset
        valid_in = 4'b0001;
        data_in  = {96'h0, 32'h55};
        exp_ret[0].push_back(32'h55);
        step();
        valid_in = '0;
        ret_pop  = 4'b0001;
        step();
        ret_pop = '0;
        repeat (2) step();

        chk("recir_queue_empty", BW'(exp_recir.size()), 128'h0);
        for (int i = 0; i < LANES; i++)
            chk($sformatf("ret_queue_empty_l%0d", i), BW'(exp_ret[i].size()), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/recirc_router_fifo.md
Name: recirc_router_fifo

Overview:
Parametrised, registered successor to the PHY TX recirculation stage. It steers LANES parallel data lanes either onto the recirculation path or into per-lane return FIFOs. Steering is controlled by a mode bit that changes only on idle cycles, so a burst is never split between the two paths. The block sits between the TX lane source and the recirculation/return consumers.

Parameters:
DATA_W, 32, width of one lane word
LANES, 4, number of parallel lanes
DEPTH, 4, entries per lane return FIFO (power of two, >=2)
PTR_W, $clog2(DEPTH), FIFO pointer width (derived)

Ports:
clk  input  1  block clock, rising edge
reset_L  input  1  asynchronous active-low reset
active  input  1  requested mode: 1 = recirculate, 0 = return
valid_in  input  LANES  per-lane input valid
data_in  input  LANES*DATA_W  lane words, lane i at [i*DATA_W +: DATA_W]
mode_q  output  1  applied mode
valid_out_recir  output  LANES  registered recirculation valid
data_out_recir  output  LANES*DATA_W  registered recirculation data
ret_pop  input  LANES  per-lane return FIFO pop
ret_valid  output  LANES  return FIFO non-empty
data_out_ret  output  LANES*DATA_W  return FIFO head (show-ahead)
ret_full  output  LANES  return FIFO full
overflow  output  LANES  sticky drop flag

Behaviour:
- Clock is clk. Reset is reset_L, asynchronous and active-low. While reset_L=0: mode_q=0, valid_out_recir=0, data_out_recir=0, all FIFOs empty (ret_valid=0, data_out_ret=0, ret_full=0), overflow=0. Reset mid-operation discards all FIFO contents immediately.
- Mode update: on each clock edge, if valid_in==0 then mode_q<=active; otherwise mode_q holds. A pending request is applied at the first all-idle cycle.
- Steering in cycle t uses mode_q as it was before that edge. The mode update and the steering of that cycle's data never interact.
- Recirculation path (mode_q=1): valid_out_recir[i]<=valid_in[i], and lane data<=data_in lane. Latency is 1 cycle.
- When mode_q=0 or valid_in[i]=0: valid_out_recir[i]<=0 and lane data<=0. No stale data is left on the bus.
- Return path (mode_q=0, valid_in[i]=1): push data_in lane i into FIFO i.
  - Push is accepted if the FIFO is not full, or if ret_pop[i]=1 in the same cycle (simultaneous pop+push when full keeps the count at DEPTH).
  - A rejected push drops the word and sets overflow[i]<=1. The flag is sticky and cleared only by reset.
- Pop: ret_pop[i]=1 with ret_valid[i]=1 removes the head. A pop on an empty FIFO is ignored with no error.
- Simultaneous push+pop on an empty FIFO: the push is stored and the pop is ignored.
- FIFO output: data_out_ret lane = head entry when count>0, else 0. ret_valid[i]=(count!=0). ret_full[i]=(count==DEPTH). All three are combinational from FIFO state.
- Pointers wrap modulo DEPTH. The count is PTR_W+1 bits wide.
- Data ordering is strictly FIFO per lane. Lanes are independent.

Decomposition:
- Shared package tx_pkg: DATA_W_DEF=32, MODE_RETURN=1'b0, MODE_RECIR=1'b1.
- Sub-module recirc_ret_fifo (DATA_W, DEPTH): one lane FIFO with push, pop, head, valid, full, and an overflow pulse. Instantiate it LANES times via generate.
- Top level holds the mode register, the recirculation registers, and the sticky overflow flags.

Test Plan:
- Reset, then active=1 with an idle cycle, then valid_in=4'b1111 with data 0xA0..A3 -> mode_q=1, and valid_out_recir=4'b1111 carries A0..A3 one cycle later. ret_valid=0.
- mode_q=1 with a burst in progress, active drops to 0 mid-burst -> burst words keep going to recirculation. mode_q=0 only after the first valid_in==0 cycle.
- mode_q=0, lane0 receives 5 words 0x1..0x5 with DEPTH=4 and no pops -> ret_full[0]=1, word 0x5 dropped, overflow[0]=1. Popping then returns 0x1, 0x2, 0x3, 0x4 in order.
- Lane0 full, push 0x9 with ret_pop[0]=1 in the same cycle -> head advances, 0x9 is stored, count stays 4, overflow unchanged.
- Pop on an empty lane -> no state change. Push+pop on an empty lane -> ret_valid=1 with head = pushed word.
- Assert reset_L=0 mid-stream with FIFOs partly filled -> all outputs go to 0 asynchronously, FIFOs are empty after release, and mode_q=0.
